// File: rtl/cs_pkg.sv
// Shared types for the CS-cipher block packer.
// Build option CS_PACKER_PAD_EN selects PKCS#7-style padding and the PAD state.
package cs_pkg;
    localparam int BLOCK_BYTES = 8;

    typedef logic [63:0] cs_block_t;

`ifdef CS_PACKER_PAD_EN
    localparam bit PAD_EN = 1'b1;
    typedef enum logic [1:0] {S_FILL, S_HOLD, S_PAD} pk_state_t;
`else
    localparam bit PAD_EN = 1'b0;
    typedef enum logic [1:0] {S_FILL, S_HOLD} pk_state_t;
`endif

    // Extra block emitted after an exactly-full message when padding is enabled.
    localparam cs_block_t PAD_BLOCK = 64'h0808080808080808;
endpackage

// File: rtl/cs_pad_fill.sv
// Completes a partial block: bytes at positions >= cnt become the pad value (8-cnt)
// when CS_PACKER_PAD_EN is defined, zero otherwise. cnt is the number of valid bytes (1..8).
module cs_pad_fill
    import cs_pkg::*;
(
    input  cs_block_t  blk,
    input  logic [3:0] cnt,
    output cs_block_t  filled
);
    logic [7:0] fill_byte;

    assign fill_byte = PAD_EN ? {4'd0, 4'd8 - cnt} : 8'd0;

    generate
        for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
            assign filled[63-8*gi -: 8] = (4'(gi) < cnt) ? blk[63-8*gi -: 8] : fill_byte;
        end
    endgenerate
endmodule

// File: rtl/cs_block_packer.sv
// Packs a tlast-delimited byte stream into 64-bit blocks (first byte in [63:56]).
// Build option CS_PACKER_PAD_EN enables PKCS#7-style padding with a trailing pad block.
module cs_block_packer
    import cs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_tvalid,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] blk_count
);
    pk_state_t        state_reg;
    cs_block_t        asm_reg;
    cs_block_t        out_data_reg;
    logic [2:0]       idx_reg;
    logic             asm_last_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             cnt_clr_reg;
    logic [CNT_W-1:0] blk_count_reg;
`ifdef CS_PACKER_PAD_EN
    logic             pad_pend_reg;
`endif

    logic      in_fire;
    logic      out_fire;
    logic      out_free;
    logic      blk_done;
    logic      need_pad;
    logic      blk_last;
    logic [5:0] shift;
    cs_block_t merged;
    cs_block_t filled;

    assign s_axis_tready = (state_reg == S_FILL) && !rst;
    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign out_fire = out_valid_reg && m_axis_tready;
    assign out_free = !out_valid_reg || m_axis_tready;

    // Byte idx lands at bit offset 8*(7-idx); the assembly register is zero between blocks.
    assign shift    = {~idx_reg, 3'b000};
    assign merged   = asm_reg | (cs_block_t'(s_axis_tdata) << shift);
    assign blk_done = (idx_reg == 3'd7) || s_axis_tlast;
    assign need_pad = PAD_EN && s_axis_tlast && (idx_reg == 3'd7);
    assign blk_last = s_axis_tlast && !need_pad;

    cs_pad_fill u_pad_fill (
        .blk    (merged),
        .cnt    ({1'b0, idx_reg} + 4'd1),
        .filled (filled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FILL;
            asm_reg       <= '0;
            out_data_reg  <= '0;
            idx_reg       <= '0;
            asm_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            cnt_clr_reg   <= 1'b0;
            blk_count_reg <= '0;
`ifdef CS_PACKER_PAD_EN
            pad_pend_reg  <= 1'b0;
`endif
        end else begin
            if (out_fire)
                out_valid_reg <= 1'b0;

            // Count is shown for one cycle after the tlast block, then cleared.
            cnt_clr_reg <= out_fire && out_last_reg;
            if (cnt_clr_reg)
                blk_count_reg <= out_fire ? CNT_W'(1) : '0;
            else if (out_fire && blk_count_reg != '1)
                blk_count_reg <= blk_count_reg + CNT_W'(1);

            case (state_reg)
                S_FILL: begin
                    if (in_fire) begin
                        if (blk_done) begin
                            idx_reg <= '0;
                            if (out_free) begin
                                out_data_reg  <= filled;
                                out_last_reg  <= blk_last;
                                out_valid_reg <= 1'b1;
                                asm_reg       <= '0;
`ifdef CS_PACKER_PAD_EN
                                state_reg     <= need_pad ? S_PAD : S_FILL;
`endif
                            end else begin
                                asm_reg      <= filled;
                                asm_last_reg <= blk_last;
`ifdef CS_PACKER_PAD_EN
                                pad_pend_reg <= need_pad;
`endif
                                state_reg    <= S_HOLD;
                            end
                        end else begin
                            asm_reg <= merged;
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_fire) begin
                        out_data_reg  <= asm_reg;
                        out_last_reg  <= asm_last_reg;
                        out_valid_reg <= 1'b1;
                        asm_reg       <= '0;
`ifdef CS_PACKER_PAD_EN
                        state_reg     <= pad_pend_reg ? S_PAD : S_FILL;
`else
                        state_reg     <= S_FILL;
`endif
                    end
                end
`ifdef CS_PACKER_PAD_EN
                S_PAD: begin
                    if (out_free) begin
                        out_data_reg  <= PAD_BLOCK;
                        out_last_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_FILL;
                    end
                end
`endif
                default: state_reg <= S_FILL;
            endcase
        end
    end

    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tlast  = out_last_reg;
    assign blk_count     = blk_count_reg;
endmodule
